// File: rtl/para_smooth.sv
// para_smooth: boxcar moving-average smoother ahead of hit detection.
// Averages the last 2^k raw ADC samples (k register-selected, clamped to
// LOG2_MAX) with a warm-up phase, a bypass mode and register-file status.
//
// Ports:
//   clk_sys      in   system clock
//   rst          in   synchronous active-high reset
//   ad_data      in   raw unsigned ADC sample (DW bits)
//   ad_vld       in   sample strobe, one cycle per sample
//   cfg_sm_en    in   1 = average, 0 = bypass
//   cfg_sm_shift in   window exponent k (window length 2^k)
//   stu_sm_fill  out  window full, averaged stream running
//   stu_sm_cnt   out  wrapping count of sm_vld pulses
//   sm_data      out  smoothed sample (DW bits)
//   sm_vld       out  smoothed sample strobe
`timescale 1ns/1ps

module para_smooth #(
    parameter int DW       = 16,
    parameter int LOG2_MAX = 4
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic [DW-1:0] ad_data,
    input  logic          ad_vld,
    input  logic          cfg_sm_en,
    input  logic [2:0]    cfg_sm_shift,
    output logic          stu_sm_fill,
    output logic [15:0]   stu_sm_cnt,
    output logic [DW-1:0] sm_data,
    output logic          sm_vld
);

    localparam int DEPTH = 1 << LOG2_MAX;
    localparam int SW    = DW + LOG2_MAX;
    localparam int PW    = LOG2_MAX;
    localparam logic [2:0] KMAX = 3'(LOG2_MAX);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_buf [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW:0]   r_fill;
    logic [SW-1:0] r_sum;
    logic [2:0]    r_shift_q;
    logic          r_en_q;
    logic [DW-1:0] r_sm_data;
    logic          r_sm_vld;
    logic [15:0]   r_cnt;

    logic [2:0]    w_keff;
    logic [PW:0]   w_n;
    logic [PW:0]   w_nm1;
    logic [PW-1:0] w_rptr;
    logic [DW-1:0] w_oldest;
    logic          w_cfg_chg;
    logic [SW-1:0] w_sum_nxt;
    logic [PW:0]   w_fill_nxt;
    logic          w_wr;
    logic          w_out_vld;
    logic [DW-1:0] w_out_data;

    // Datapath runs on the registered config so that the sample arriving
    // in the cycle a change is seen is still handled under the old setting.
    assign w_keff    = (r_shift_q > KMAX) ? KMAX : r_shift_q;
    assign w_n       = (PW+1)'(1) << w_keff;
    assign w_nm1     = w_n - (PW+1)'(1);
    // With N = DEPTH the oldest slot is the one about to be overwritten.
    assign w_rptr    = r_wptr - w_n[PW-1:0];
    assign w_oldest  = r_buf[w_rptr];
    assign w_cfg_chg = (cfg_sm_shift != r_shift_q) || (cfg_sm_en != r_en_q);

    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_fill_nxt  = r_fill;
        w_wr        = 1'b0;
        w_out_vld   = 1'b0;
        w_out_data  = r_sm_data;
        unique case (r_state)
            S_FLUSH: begin
                w_sum_nxt   = '0;
                w_fill_nxt  = '0;
                w_state_nxt = S_FILL;
            end
            S_FILL: begin
                if (!r_en_q) begin
                    w_fill_nxt = '0;
                    w_out_vld  = ad_vld;
                    if (ad_vld)
                        w_out_data = ad_data;
                end else if (ad_vld) begin
                    w_wr      = 1'b1;
                    w_sum_nxt = r_sum + SW'(ad_data);
                    if (r_fill == w_nm1) begin
                        w_out_vld   = 1'b1;
                        w_out_data  = DW'(w_sum_nxt >> w_keff);
                        w_state_nxt = S_RUN;
                    end else begin
                        w_fill_nxt = r_fill + (PW+1)'(1);
                    end
                end
            end
            S_RUN: begin
                if (ad_vld) begin
                    w_wr       = 1'b1;
                    w_sum_nxt  = r_sum + SW'(ad_data) - SW'(w_oldest);
                    w_out_vld  = 1'b1;
                    w_out_data = DW'(w_sum_nxt >> w_keff);
                end
            end
            default: begin
                w_state_nxt = S_FLUSH;
            end
        endcase
        if (w_cfg_chg)
            w_state_nxt = S_FLUSH;
    end

    always_ff @(posedge clk_sys) begin
        r_shift_q <= cfg_sm_shift;
        r_en_q    <= cfg_sm_en;
        if (rst) begin
            r_state   <= S_FILL;
            r_wptr    <= '0;
            r_fill    <= '0;
            r_sum     <= '0;
            r_sm_data <= '0;
            r_sm_vld  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_fill    <= w_fill_nxt;
            r_sum     <= w_sum_nxt;
            r_sm_data <= w_out_data;
            r_sm_vld  <= w_out_vld;
            if (w_wr)
                r_wptr <= r_wptr + PW'(1);
            if (w_out_vld)
                r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_wr && !rst)
            r_buf[r_wptr] <= ad_data;
    end

    assign stu_sm_fill = (r_state == S_RUN);
    assign stu_sm_cnt  = r_cnt;
    assign sm_data     = r_sm_data;
    assign sm_vld      = r_sm_vld;

endmodule

// File: tb/tb_para_smooth.sv
// tb_para_smooth: directed self-checking bench for para_smooth.
// Drives on falling edges, samples 1ns after rising edges.
`timescale 1ns/1ps

module tb_para_smooth;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ad_data = '0;
    logic        ad_vld = 1'b0;
    logic        cfg_sm_en = 1'b1;
    logic [2:0]  cfg_sm_shift = 3'd2;
    logic        stu_sm_fill;
    logic [15:0] stu_sm_cnt;
    logic [15:0] sm_data;
    logic        sm_vld;

    int checks = 0;
    int errors = 0;

    para_smooth #(.DW(16), .LOG2_MAX(4)) dut (
        .clk_sys      (clk_sys),
        .rst          (rst),
        .ad_data      (ad_data),
        .ad_vld       (ad_vld),
        .cfg_sm_en    (cfg_sm_en),
        .cfg_sm_shift (cfg_sm_shift),
        .stu_sm_fill  (stu_sm_fill),
        .stu_sm_cnt   (stu_sm_cnt),
        .sm_data      (sm_data),
        .sm_vld       (sm_vld)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Two reset edges with the new config applied; returns at a falling edge.
    task automatic do_reset(input logic [2:0] k, input logic en);
        @(negedge clk_sys);
        cfg_sm_shift = k;
        cfg_sm_en    = en;
        ad_vld       = 1'b0;
        rst          = 1'b1;
        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(3'd2, 1'b1);
        checks++;
        if (sm_data !== 16'd0 || sm_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got data=%h vld=%b expected 0 0", sm_data, sm_vld);
        end
        checks++;
        if (stu_sm_fill !== 1'b0 || stu_sm_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stat: got fill=%b cnt=%0d expected 0 0", stu_sm_fill, stu_sm_cnt);
        end
    endtask

    task automatic test_warmup;
        logic [15:0] d  [6] = '{16'd4, 16'd8, 16'd12, 16'd16, 16'd20, 16'd24};
        logic        ev [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] ed [6] = '{16'd0, 16'd0, 16'd0, 16'd10, 16'd14, 16'd18};
        for (int i = 0; i < 6; i++) begin
            ad_data = d[i];
            ad_vld  = 1'b1;
            @(posedge clk_sys);
            #1;
            checks++;
            if (sm_vld !== ev[i] || stu_sm_fill !== ev[i]) begin
                errors++;
                $display("FAIL warmup_vld[%0d]: got vld=%b fill=%b expected %b", i, sm_vld, stu_sm_fill, ev[i]);
            end
            if (ev[i]) begin
                checks++;
                if (sm_data !== ed[i]) begin
                    errors++;
                    $display("FAIL warmup_data[%0d]: got %0d expected %0d", i, sm_data, ed[i]);
                end
            end
            @(negedge clk_sys);
        end
        ad_vld = 1'b0;
        checks++;
        if (stu_sm_cnt !== 16'd3) begin
            errors++;
            $display("FAIL warmup_cnt: got %0d expected 3", stu_sm_cnt);
        end
    endtask

    task automatic test_gapped;
        logic [15:0] d  [6] = '{16'd4, 16'd8, 16'd12, 16'd16, 16'd20, 16'd24};
        logic        ev [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] ed [6] = '{16'd0, 16'd0, 16'd0, 16'd10, 16'd14, 16'd18};
        logic [15:0] hold = 16'd0;
        do_reset(3'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            ad_data = d[i];
            ad_vld  = 1'b1;
            @(posedge clk_sys);
            #1;
            if (ev[i])
                hold = ed[i];
            checks++;
            if (sm_vld !== ev[i] || sm_data !== hold) begin
                errors++;
                $display("FAIL gap_sample[%0d]: got vld=%b data=%0d expected %b %0d", i, sm_vld, sm_data, ev[i], hold);
            end
            @(negedge clk_sys);
            ad_vld = 1'b0;
            for (int j = 0; j < 3; j++) begin
                @(posedge clk_sys);
                #1;
                checks++;
                if (sm_vld !== 1'b0 || sm_data !== hold) begin
                    errors++;
                    $display("FAIL gap_idle[%0d.%0d]: got vld=%b data=%0d expected 0 %0d", i, j, sm_vld, sm_data, hold);
                end
                @(negedge clk_sys);
            end
        end
    endtask

    task automatic test_full_scale;
        do_reset(3'd7, 1'b1);
        for (int i = 0; i < 16; i++) begin
            ad_data = 16'hFFFF;
            ad_vld  = 1'b1;
            @(posedge clk_sys);
            #1;
            checks++;
            if (sm_vld !== (i == 15)) begin
                errors++;
                $display("FAIL clamp_vld[%0d]: got %b expected %b", i, sm_vld, (i == 15));
            end
            @(negedge clk_sys);
        end
        checks++;
        if (sm_data !== 16'hFFFF || stu_sm_fill !== 1'b1) begin
            errors++;
            $display("FAIL full_scale: got data=%h fill=%b expected ffff 1", sm_data, stu_sm_fill);
        end
        ad_data = 16'h0000;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b1 || sm_data !== 16'hEFFF) begin
            errors++;
            $display("FAIL full_scale_drop: got vld=%b data=%h expected 1 efff", sm_vld, sm_data);
        end
        @(negedge clk_sys);
        ad_vld = 1'b0;
    endtask

    task automatic test_bypass;
        cfg_sm_en = 1'b0;
        repeat (3) @(negedge clk_sys);
        checks++;
        if (sm_vld !== 1'b0 || stu_sm_fill !== 1'b0) begin
            errors++;
            $display("FAIL bypass_idle: got vld=%b fill=%b expected 0 0", sm_vld, stu_sm_fill);
        end
        ad_data = 16'h1234;
        ad_vld  = 1'b1;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b1 || sm_data !== 16'h1234 || stu_sm_fill !== 1'b0) begin
            errors++;
            $display("FAIL bypass_pass: got vld=%b data=%h fill=%b expected 1 1234 0", sm_vld, sm_data, stu_sm_fill);
        end
        @(negedge clk_sys);
        ad_vld = 1'b0;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b0 || sm_data !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_hold: got vld=%b data=%h expected 0 1234", sm_vld, sm_data);
        end
        @(negedge clk_sys);
        ad_data = 16'hABCD;
        ad_vld  = 1'b1;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b1 || sm_data !== 16'hABCD) begin
            errors++;
            $display("FAIL bypass_b2b0: got vld=%b data=%h expected 1 abcd", sm_vld, sm_data);
        end
        @(negedge clk_sys);
        ad_data = 16'h0001;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b1 || sm_data !== 16'h0001) begin
            errors++;
            $display("FAIL bypass_b2b1: got vld=%b data=%h expected 1 0001", sm_vld, sm_data);
        end
        @(negedge clk_sys);
        ad_vld = 1'b0;
        checks++;
        if (stu_sm_cnt !== 16'd5) begin
            errors++;
            $display("FAIL bypass_cnt: got %0d expected 5", stu_sm_cnt);
        end
    endtask

    task automatic test_cfg_change;
        logic [15:0] d [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        do_reset(3'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ad_data = d[i];
            ad_vld  = 1'b1;
            @(negedge clk_sys);
        end
        ad_vld = 1'b0;
        checks++;
        if (sm_vld !== 1'b1 || sm_data !== 16'd2 || stu_sm_fill !== 1'b1) begin
            errors++;
            $display("FAIL chg_pre: got vld=%b data=%0d fill=%b expected 1 2 1", sm_vld, sm_data, stu_sm_fill);
        end
        cfg_sm_shift = 3'd1;
        @(posedge clk_sys);
        #1;
        checks++;
        if (stu_sm_fill !== 1'b0) begin
            errors++;
            $display("FAIL chg_flush_fill: got %b expected 0", stu_sm_fill);
        end
        @(negedge clk_sys);
        ad_data = 16'd100;
        ad_vld  = 1'b1;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b0 || stu_sm_cnt !== 16'd1) begin
            errors++;
            $display("FAIL chg_drop: got vld=%b cnt=%0d expected 0 1", sm_vld, stu_sm_cnt);
        end
        @(negedge clk_sys);
        ad_data = 16'd6;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b0 || stu_sm_fill !== 1'b0) begin
            errors++;
            $display("FAIL chg_fill1: got vld=%b fill=%b expected 0 0", sm_vld, stu_sm_fill);
        end
        @(negedge clk_sys);
        ad_data = 16'd10;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b1 || sm_data !== 16'd8 || stu_sm_fill !== 1'b1) begin
            errors++;
            $display("FAIL chg_out: got vld=%b data=%0d fill=%b expected 1 8 1", sm_vld, sm_data, stu_sm_fill);
        end
        @(negedge clk_sys);
        ad_vld = 1'b0;
        checks++;
        if (stu_sm_cnt !== 16'd2) begin
            errors++;
            $display("FAIL chg_cnt: got %0d expected 2", stu_sm_cnt);
        end
    endtask

    task automatic test_reset_run;
        ad_data = 16'd20;
        ad_vld  = 1'b1;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b1 || sm_data !== 16'd15) begin
            errors++;
            $display("FAIL rrun_pre: got vld=%b data=%0d expected 1 15", sm_vld, sm_data);
        end
        @(negedge clk_sys);
        ad_vld = 1'b0;
        rst    = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        checks++;
        if (sm_data !== 16'd0 || sm_vld !== 1'b0 || stu_sm_fill !== 1'b0 || stu_sm_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rrun_zero: got data=%0d vld=%b fill=%b cnt=%0d expected 0 0 0 0", sm_data, sm_vld, stu_sm_fill, stu_sm_cnt);
        end
        ad_data = 16'd3;
        ad_vld  = 1'b1;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b0) begin
            errors++;
            $display("FAIL rrun_warm: got vld=%b expected 0", sm_vld);
        end
        @(negedge clk_sys);
        ad_data = 16'd5;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b1 || sm_data !== 16'd4) begin
            errors++;
            $display("FAIL rrun_out: got vld=%b data=%0d expected 1 4", sm_vld, sm_data);
        end
        @(negedge clk_sys);
        ad_vld = 1'b0;
    endtask

    task automatic test_n1;
        do_reset(3'd0, 1'b1);
        ad_data = 16'd7;
        ad_vld  = 1'b1;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b1 || sm_data !== 16'd7 || stu_sm_fill !== 1'b1) begin
            errors++;
            $display("FAIL n1_first: got vld=%b data=%0d fill=%b expected 1 7 1", sm_vld, sm_data, stu_sm_fill);
        end
        @(negedge clk_sys);
        ad_data = 16'd9;
        @(posedge clk_sys);
        #1;
        checks++;
        if (sm_vld !== 1'b1 || sm_data !== 16'd9) begin
            errors++;
            $display("FAIL n1_second: got vld=%b data=%0d expected 1 9", sm_vld, sm_data);
        end
        @(negedge clk_sys);
        ad_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_gapped();
        test_full_scale();
        test_bypass();
        test_cfg_change();
        test_reset_run();
        test_n1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
